// File: rtl/pad_pkg.sv
// Shared definitions for the GPIO pad-ring sequencer: FSM state encoding,
// drive-mode constants and pad-ring geometry.
package pad_pkg;

    // Power-on ramp states followed by the runtime per-pad config sequence.
    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_EN_IO   = 3'd1,
        S_EN_H    = 3'd2,
        S_REL     = 3'd3,
        S_RUN     = 3'd4,
        S_CFG_HLD = 3'd5,
        S_CFG_UPD = 3'd6,
        S_CFG_REL = 3'd7
    } pad_seq_state_e;

    // Strong pull-up / strong pull-down drive mode.
    localparam logic [2:0] DM_STRONG = 3'b110;

    // Ring geometry: four sides of nine pads, flat index = side*9 + pad.
    localparam int PADS_PER_SIDE = 9;
    localparam int WE = 0;
    localparam int NO = 1;
    localparam int EA = 2;
    localparam int SO = 3;

    // Width of the pad index on the config request interface.
    localparam int PAD_IDX_W = 6;

    // Flat pad index from side and position along that side.
    function automatic int pad_flat_index(input int side, input int pad);
        return side * PADS_PER_SIDE + pad;
    endfunction

endpackage

// File: rtl/pad_ring_seq.sv
// Power-on sequencer and runtime drive-mode controller for the GPIO pad ring.
// Ramps enable_vddio, then enable_h, then releases the pad holds, and after
// that services dm/slow writes to one pad at a time by holding that pad,
// updating its config, and releasing it again. Every output is a register.
module pad_ring_seq
    import pad_pkg::*;
#(
    parameter int         NUM_PADS    = 36,   // at most 2**PAD_IDX_W
    parameter int         STEP_CYCLES = 256,  // >= 1
    parameter int         HOLD_CYCLES = 16,   // >= 1
    parameter logic [2:0] DM_RESET    = DM_STRONG
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [PAD_IDX_W-1:0]    cfg_pad_i,
    input  logic [2:0]              cfg_dm_i,
    input  logic                    cfg_slow_i,
    output logic                    cfg_err_o,
    output logic                    ramp_done_o,
    output logic                    pad_en_vddio_o,
    output logic                    pad_en_h_o,
    output logic [NUM_PADS-1:0]     pad_hld_h_n_o,
    output logic [3*NUM_PADS-1:0]   pad_dm_o,
    output logic [NUM_PADS-1:0]     pad_slow_o
);

    localparam int CNT_MAX = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // A waiting state spends LOAD+1 cycles: it is entered with LOAD and
    // leaves on the cycle the counter is already zero.
    localparam logic [CNT_W-1:0]     STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [PAD_IDX_W:0]   NUM_PADS_W = (PAD_IDX_W + 1)'(NUM_PADS);

    pad_seq_state_e             state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic                       en_vddio_reg, en_vddio_next;
    logic                       en_h_reg, en_h_next;
    logic [NUM_PADS-1:0]        hld_reg, hld_next;
    logic [3*NUM_PADS-1:0]      dm_reg, dm_next;
    logic [NUM_PADS-1:0]        slow_reg, slow_next;
    logic                       ready_reg, ready_next;
    logic                       err_reg, err_next;
    logic                       done_reg, done_next;
    logic [PAD_IDX_W-1:0]       pad_lat_reg, pad_lat_next;
    logic [2:0]                 dm_lat_reg, dm_lat_next;
    logic                       slow_lat_reg, slow_lat_next;

    logic                       accept;
    logic                       pad_in_range;
    logic                       cnt_zero;
    logic [NUM_PADS-1:0]        req_sel;
    logic [NUM_PADS-1:0]        lat_sel;
    logic [3*NUM_PADS-1:0]      dm_upd;
    logic [NUM_PADS-1:0]        slow_upd;

    assign accept       = ready_reg & cfg_valid_i;
    assign pad_in_range = ({1'b0, cfg_pad_i} < NUM_PADS_W);
    assign cnt_zero     = (cnt_reg == '0);

    // Per-pad one-hot selects and the config vectors with the latched pad
    // replaced; out-of-range indices select nothing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            assign req_sel[gi]          = (cfg_pad_i == PAD_IDX_W'(gi));
            assign lat_sel[gi]          = (pad_lat_reg == PAD_IDX_W'(gi));
            assign dm_upd[3*gi +: 3]    = lat_sel[gi] ? dm_lat_reg : dm_reg[3*gi +: 3];
            assign slow_upd[gi]         = lat_sel[gi] ? slow_lat_reg : slow_reg[gi];
        end
    endgenerate

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so they appear registered on entry.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        en_vddio_next = en_vddio_reg;
        en_h_next     = en_h_reg;
        hld_next      = hld_reg;
        dm_next       = dm_reg;
        slow_next     = slow_reg;
        ready_next    = 1'b0;
        err_next      = 1'b0;
        done_next     = done_reg;
        pad_lat_next  = pad_lat_reg;
        dm_lat_next   = dm_lat_reg;
        slow_lat_next = slow_lat_reg;

        case (state_reg)
            S_OFF: begin
                state_next    = S_EN_IO;
                cnt_next      = STEP_LOAD;
                en_vddio_next = 1'b1;
            end
            S_EN_IO: begin
                if (cnt_zero) begin
                    state_next = S_EN_H;
                    cnt_next   = STEP_LOAD;
                    en_h_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_EN_H: begin
                if (cnt_zero) begin
                    state_next = S_REL;
                    cnt_next   = STEP_LOAD;
                    hld_next   = '1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_REL: begin
                if (cnt_zero) begin
                    state_next = S_RUN;
                    done_next  = 1'b1;
                    ready_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_RUN: begin
                ready_next = 1'b1;
                if (accept) begin
                    if (pad_in_range) begin
                        state_next    = S_CFG_HLD;
                        cnt_next      = HOLD_LOAD;
                        ready_next    = 1'b0;
                        hld_next      = hld_reg & ~req_sel;
                        pad_lat_next  = cfg_pad_i;
                        dm_lat_next   = cfg_dm_i;
                        slow_lat_next = cfg_slow_i;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_CFG_HLD: begin
                if (cnt_zero) begin
                    state_next = S_CFG_UPD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_CFG_UPD: begin
                state_next = S_CFG_REL;
                cnt_next   = HOLD_LOAD;
                dm_next    = dm_upd;
                slow_next  = slow_upd;
                hld_next   = hld_reg | lat_sel;
            end
            S_CFG_REL: begin
                if (cnt_zero) begin
                    state_next = S_RUN;
                    ready_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = S_OFF;
            end
        endcase
    end

    // State, counter and output registers; reset forces the ring fully off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= S_OFF;
            cnt_reg      <= '0;
            en_vddio_reg <= 1'b0;
            en_h_reg     <= 1'b0;
            hld_reg      <= '0;
            dm_reg       <= {NUM_PADS{DM_RESET}};
            slow_reg     <= '0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
            done_reg     <= 1'b0;
            pad_lat_reg  <= '0;
            dm_lat_reg   <= '0;
            slow_lat_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            en_vddio_reg <= en_vddio_next;
            en_h_reg     <= en_h_next;
            hld_reg      <= hld_next;
            dm_reg       <= dm_next;
            slow_reg     <= slow_next;
            ready_reg    <= ready_next;
            err_reg      <= err_next;
            done_reg     <= done_next;
            pad_lat_reg  <= pad_lat_next;
            dm_lat_reg   <= dm_lat_next;
            slow_lat_reg <= slow_lat_next;
        end
    end

    assign cfg_ready_o    = ready_reg;
    assign cfg_err_o      = err_reg;
    assign ramp_done_o    = done_reg;
    assign pad_en_vddio_o = en_vddio_reg;
    assign pad_en_h_o     = en_h_reg;
    assign pad_hld_h_n_o  = hld_reg;
    assign pad_dm_o       = dm_reg;
    assign pad_slow_o     = slow_reg;

endmodule

// File: tb/tb_pad_ring_seq.sv
// Self-checking bench for pad_ring_seq with short ramp/hold timing.
module tb_pad_ring_seq;
    import pad_pkg::*;

    localparam int NP   = 36;
    localparam int STEP = 4;
    localparam int HOLD = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [5:0]         cfg_pad = '0;
    logic [2:0]         cfg_dm = '0;
    logic               cfg_slow = 1'b0;
    logic               cfg_ready;
    logic               cfg_err;
    logic               ramp_done;
    logic               en_vddio;
    logic               en_h;
    logic [NP-1:0]      hld_n;
    logic [3*NP-1:0]    dm;
    logic [NP-1:0]      slow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the steady RUN configuration of every pad.
    logic [2:0] m_dm   [NP];
    logic       m_slow [NP];

    typedef struct {
        int   cyc;
        logic vddio;
        logic h;
        logic hld_on;
        logic done;
    } ramp_vec_t;
    ramp_vec_t rt[8];

    always #5 clk = ~clk;

    pad_ring_seq #(
        .NUM_PADS    (NP),
        .STEP_CYCLES (STEP),
        .HOLD_CYCLES (HOLD),
        .DM_RESET    (3'b110)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_pad_i      (cfg_pad),
        .cfg_dm_i       (cfg_dm),
        .cfg_slow_i     (cfg_slow),
        .cfg_err_o      (cfg_err),
        .ramp_done_o    (ramp_done),
        .pad_en_vddio_o (en_vddio),
        .pad_en_h_o     (en_h),
        .pad_hld_h_n_o  (hld_n),
        .pad_dm_o       (dm),
        .pad_slow_o     (slow)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ramp ordering must hold in every cycle, including across resets.
    always @(negedge clk) begin
        n_vec++;
        if ((en_h && !en_vddio) || ((|hld_n) && !en_h)) begin
            n_err++;
            $display("FAIL ramp_order: vddio=%b h=%b hld=%0h required ordered ramp", en_vddio, en_h, hld_n);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3*NP-1:0] model_dm();
        logic [3*NP-1:0] v;
        for (int i = 0; i < NP; i++) v[3*i +: 3] = m_dm[i];
        return v;
    endfunction

    function automatic logic [NP-1:0] model_slow();
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = m_slow[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_dm[i]   = 3'b110;
            m_slow[i] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [3*NP-1:0] all_strong;
        for (int i = 0; i < NP; i++) all_strong[3*i +: 3] = 3'b110;
        check({tag, "_vddio"}, en_vddio, 0);
        check({tag, "_en_h"},  en_h, 0);
        check({tag, "_hld"},   hld_n, 0);
        check({tag, "_dm"},    dm, all_strong);
        check({tag, "_slow"},  slow, 0);
        check({tag, "_ready"}, cfg_ready, 0);
        check({tag, "_err"},   cfg_err, 0);
        check({tag, "_done"},  ramp_done, 0);
    endtask

    // Releases reset (currently asserted) and walks the ramp table.
    task automatic do_ramp();
        int cur;
        logic [NP-1:0] e_hld;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cur = 0;
        $display("txn ramp start");
        for (int k = 0; k < 8; k++) begin
            while (cur < rt[k].cyc) begin
                step();
                cur++;
            end
            e_hld = rt[k].hld_on ? '1 : '0;
            check($sformatf("ramp_vddio_c%0d", cur), en_vddio, rt[k].vddio);
            check($sformatf("ramp_en_h_c%0d", cur), en_h, rt[k].h);
            check($sformatf("ramp_hld_c%0d", cur), hld_n, e_hld);
            check($sformatf("ramp_done_c%0d", cur), ramp_done, rt[k].done);
            check($sformatf("ramp_ready_c%0d", cur), cfg_ready, rt[k].done);
            check($sformatf("ramp_err_c%0d", cur), cfg_err, 0);
        end
    endtask

    // One request issued from RUN; checks every cycle until RUN is back.
    task automatic cfg_txn(input int pad, input logic [2:0] ndm, input logic ns, input bit keep);
        logic [NP-1:0]   e_hld;
        logic [3*NP-1:0] e_dm;
        logic [NP-1:0]   e_slow;
        cfg_valid = 1'b1;
        cfg_pad   = 6'(pad);
        cfg_dm    = ndm;
        cfg_slow  = ns;
        step();
        if (!keep) cfg_valid = 1'b0;
        $display("txn cfg pad=%0d dm=%b slow=%b", pad, ndm, ns);
        if (pad >= NP) begin
            check("bad_err_pulse", cfg_err, 1);
            check("bad_ready", cfg_ready, 1);
            check("bad_hld", hld_n, {NP{1'b1}});
            check("bad_dm", dm, model_dm());
            check("bad_slow", slow, model_slow());
            step();
            check("bad_err_clear", cfg_err, 0);
            check("bad_ready2", cfg_ready, 1);
        end else begin
            for (int j = 0; j <= 2*HOLD+1; j++) begin
                e_hld = '1;
                if (j <= HOLD) e_hld[pad] = 1'b0;
                e_dm   = model_dm();
                e_slow = model_slow();
                if (j >= HOLD+1) begin
                    e_dm[3*pad +: 3] = ndm;
                    e_slow[pad]      = ns;
                end
                check($sformatf("cfg_hld_j%0d", j), hld_n, e_hld);
                check($sformatf("cfg_dm_j%0d", j), dm, e_dm);
                check($sformatf("cfg_slow_j%0d", j), slow, e_slow);
                check($sformatf("cfg_ready_j%0d", j), cfg_ready, (j == 2*HOLD+1));
                check($sformatf("cfg_err_j%0d", j), cfg_err, 0);
                check($sformatf("cfg_done_j%0d", j), ramp_done, 1);
                if (j < 2*HOLD+1) step();
            end
            m_dm[pad]   = ndm;
            m_slow[pad] = ns;
        end
    endtask

    initial begin
        int p;
        logic [2:0] rdm;
        logic rs;

        rt[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0};
        rt[1] = '{1,  1'b1, 1'b0, 1'b0, 1'b0};
        rt[2] = '{4,  1'b1, 1'b0, 1'b0, 1'b0};
        rt[3] = '{5,  1'b1, 1'b1, 1'b0, 1'b0};
        rt[4] = '{8,  1'b1, 1'b1, 1'b0, 1'b0};
        rt[5] = '{9,  1'b1, 1'b1, 1'b1, 1'b0};
        rt[6] = '{12, 1'b1, 1'b1, 1'b1, 1'b0};
        rt[7] = '{13, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state while the clock runs.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        model_reset();
        do_ramp();

        // Directed writes: pad 10, bad index 40, and a repeat of pad 10.
        cfg_txn(10, 3'b001, 1'b1, 1'b0);
        cfg_txn(40, 3'b011, 1'b1, 1'b0);
        cfg_txn(10, 3'b001, 1'b1, 1'b0);

        // Randomized requests with idle gaps.
        for (int t = 0; t < 24; t++) begin
            p   = int'($urandom_range(0, 47));
            rdm = 3'($urandom);
            rs  = 1'($urandom);
            cfg_txn(p, rdm, rs, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                step();
                check("idle_hld", hld_n, {NP{1'b1}});
                check("idle_dm", dm, model_dm());
                check("idle_ready", cfg_ready, 1);
            end
        end

        // Reset asserted in the middle of the hold window.
        cfg_valid = 1'b1;
        cfg_pad   = 6'd10;
        cfg_dm    = 3'b000;
        cfg_slow  = 1'b0;
        step();
        cfg_valid = 1'b0;
        step();
        check("midhld_hld10", hld_n[10], 0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn reset mid hold");
        check_reset_outputs("midhld");
        model_reset();
        do_ramp();

        // Reset asserted during the enable_h step.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step();
        check("midh_en_h", en_h, 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn reset mid en_h");
        check_reset_outputs("midh");
        do_ramp();

        // Request held from reset; serviced only once RUN is reached,
        // then back-to-back pads 0 and 35.
        rst_n     = 1'b0;
        cfg_valid = 1'b1;
        cfg_pad   = 6'd0;
        cfg_dm    = 3'b010;
        cfg_slow  = 1'b1;
        model_reset();
        #3;
        do_ramp();
        check("early_hld0_not_yet", hld_n[0], 1);
        cfg_txn(0, 3'b010, 1'b1, 1'b1);
        cfg_txn(35, 3'b101, 1'b0, 1'b0);
        step();
        check("final_hld", hld_n, {NP{1'b1}});
        check("final_dm", dm, model_dm());
        check("final_slow", slow, model_slow());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
